// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory port arbiter
// Purpose: FSM state encoding, load/store type codes, request enable bit
//          positions and the access alignment check shared by arbiter files.
// Ports:   none (package).
package mem_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACC_I  = 3'd1,
    S_ACC_D  = 3'd2,
    S_RESP_I = 3'd3,
    S_RESP_D = 3'd4
  } state_e;

  // Load funct3 codes carried in DMEM_READ[2:0]
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store type codes carried in DMEM_WRITE[1:0]
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  // Enable bit positions inside DMEM_READ / DMEM_WRITE
  localparam int LD_EN_BIT = 3;
  localparam int ST_EN_BIT = 2;

  // Unknown load codes (011/110/111) behave as LW, unknown store code as SW.
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [1:0] st_type,
                                         input logic [2:0] ld_f3,
                                         input logic [1:0] off);
    logic mis;
    if (is_store) begin
      case (st_type)
        ST_SB:   mis = 1'b0;
        ST_SH:   mis = off[0];
        default: mis = (off != 2'b00);
      endcase
    end else begin
      case (ld_f3)
        F3_LB, F3_LBU: mis = 1'b0;
        F3_LH, F3_LHU: mis = off[0];
        default:       mis = (off != 2'b00);
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// rtl/mem_port_arbiter_lane_align.sv - byte-lane steering for stores and loads
// Purpose: combinational lane alignment. Store side: byte enables and
//          lane-replicated write data. Load side: byte/halfword select with
//          sign or zero extension.
// Ports:   st_type_i   store type (SB/SH/SW)
//          ld_funct3_i load funct3
//          off_i       byte offset addr[1:0]
//          wdata_i     right-aligned store data
//          rword_i     word read from memory
//          byte_en_o   store byte enables
//          wdata_o     replicated store data
//          rdata_o     extended load result
module lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  st_type_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    byte_en_o = 4'b1111;
    wdata_o   = wdata_i;
    case (st_type_i)
      ST_SB: begin
        byte_en_o = 4'b0001 << off_i;
        wdata_o   = {4{wdata_i[7:0]}};
      end
      ST_SH: begin
        byte_en_o = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{wdata_i[15:0]}};
      end
      default: begin
        byte_en_o = 4'b1111;
        wdata_o   = wdata_i;
      end
    endcase
  end

  always_comb begin
    sel_byte = rword_i[7:0];
    case (off_i)
      2'd0: sel_byte = rword_i[7:0];
      2'd1: sel_byte = rword_i[15:8];
      2'd2: sel_byte = rword_i[23:16];
      2'd3: sel_byte = rword_i[31:24];
      default: sel_byte = rword_i[7:0];
    endcase
    sel_half = off_i[1] ? rword_i[31:16] : rword_i[15:0];

    rdata_o = rword_i;
    case (ld_funct3_i)
      F3_LB:   rdata_o = {{24{sel_byte[7]}}, sel_byte};
      F3_LH:   rdata_o = {{16{sel_half[15]}}, sel_half};
      F3_LBU:  rdata_o = {24'h0, sel_byte};
      F3_LHU:  rdata_o = {16'h0, sel_half};
      default: rdata_o = rword_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one busywait memory port between fetch and data access
// Purpose: arbitrates IF fetch and MA data requests onto a single memory
//          port, runs the busywait handshake, aligns byte lanes, extends
//          loads, and keeps a one-entry last-fetch buffer.
// Ports:   CLK/RST                      clock, synchronous active-high reset
//          IMEM_READ/ADDR -> DATA/BUSYWAIT        fetch requester
//          DMEM_READ/WRITE/ADDR/DATA_WRITE ->
//            DATA_READ/BUSYWAIT/MISALIGN          data requester
//          MEM_READ/WRITE/ADDR/WRITEDATA/BYTE_EN <-
//            MEM_READDATA/BUSYWAIT                backing memory
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int IF_STARVE_LIMIT = 4,
  parameter int FETCH_BUF_EN    = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IMEM_READ,
  input  logic [31:0] IMEM_ADDR,
  output logic [31:0] IMEM_DATA,
  output logic        IMEM_BUSYWAIT,
  input  logic [3:0]  DMEM_READ,
  input  logic [2:0]  DMEM_WRITE,
  input  logic [31:0] DMEM_ADDR,
  input  logic [31:0] DMEM_DATA_WRITE,
  output logic [31:0] DMEM_DATA_READ,
  output logic        DMEM_BUSYWAIT,
  output logic        DMEM_MISALIGN,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WRITEDATA,
  output logic [3:0]  MEM_BYTE_EN,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  localparam int CW = (IF_STARVE_LIMIT < 1) ? 1 : $clog2(IF_STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(IF_STARVE_LIMIT);

  state_e          state_q, state_d;
  logic            rd_q, rd_d, wr_q, wr_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      off_q, off_d;
  logic [31:0]     imem_data_q, imem_data_d, dmem_data_q, dmem_data_d;
  logic            misalign_q, misalign_d;
  logic            buf_valid_q, buf_valid_d;
  logic [31:0]     buf_tag_q, buf_tag_d, buf_data_q, buf_data_d;
  logic [CW-1:0]   starve_q, starve_d;

  logic            ireq, dreq, is_st, dmis, dgrant, buf_hit;
  logic [3:0]      st_be;
  logic [31:0]     st_wdata, ld_ext;
  logic [31:0]     unused_st_rdata, unused_ld_wdata;
  logic [3:0]      unused_ld_be;

  assign ireq  = IMEM_READ;
  assign is_st = DMEM_WRITE[ST_EN_BIT];
  assign dreq  = DMEM_READ[LD_EN_BIT] | is_st;
  assign dmis  = is_misaligned(is_st, DMEM_WRITE[1:0], DMEM_READ[2:0], DMEM_ADDR[1:0]);
  // Data normally wins; a fetch starved for IF_STARVE_LIMIT grants takes the port.
  assign dgrant  = dreq && !(ireq && (starve_q == STARVE_MAX));
  assign buf_hit = (FETCH_BUF_EN != 0) && buf_valid_q && (buf_tag_q == IMEM_ADDR);

  // Store path works on the live request; load path on the latched type/offset.
  lane_align u_store_align (
    .st_type_i   (DMEM_WRITE[1:0]),
    .ld_funct3_i (F3_LW),
    .off_i       (DMEM_ADDR[1:0]),
    .wdata_i     (DMEM_DATA_WRITE),
    .rword_i     (32'h0),
    .byte_en_o   (st_be),
    .wdata_o     (st_wdata),
    .rdata_o     (unused_st_rdata)
  );

  lane_align u_load_align (
    .st_type_i   (ST_SW),
    .ld_funct3_i (ld_f3_q),
    .off_i       (off_q),
    .wdata_i     (32'h0),
    .rword_i     (MEM_READDATA),
    .byte_en_o   (unused_ld_be),
    .wdata_o     (unused_ld_wdata),
    .rdata_o     (ld_ext)
  );

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    ld_f3_d     = ld_f3_q;
    off_d       = off_q;
    imem_data_d = imem_data_q;
    dmem_data_d = dmem_data_q;
    misalign_d  = misalign_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    starve_d    = ireq ? starve_q : '0;

    case (state_q)
      S_IDLE: begin
        if (dgrant) begin
          if (ireq) starve_d = starve_q + 1'b1;
          if (dmis) begin
            state_d     = S_RESP_D;
            misalign_d  = 1'b1;
            dmem_data_d = '0;
          end else begin
            state_d = S_ACC_D;
            addr_d  = {DMEM_ADDR[31:2], 2'b00};
            rd_d    = ~is_st;
            wr_d    = is_st;
            be_d    = is_st ? st_be : 4'b1111;
            wdata_d = is_st ? st_wdata : '0;
            ld_f3_d = DMEM_READ[2:0];
            off_d   = DMEM_ADDR[1:0];
            // A store into the buffered instruction word makes it stale.
            if (is_st && (buf_tag_q[31:2] == DMEM_ADDR[31:2])) buf_valid_d = 1'b0;
          end
        end else if (ireq) begin
          starve_d = '0;
          if (buf_hit) begin
            state_d     = S_RESP_I;
            imem_data_d = buf_data_q;
          end else begin
            state_d     = S_ACC_I;
            addr_d      = {IMEM_ADDR[31:2], 2'b00};
            rd_d        = 1'b1;
            wr_d        = 1'b0;
            be_d        = 4'b1111;
            wdata_d     = '0;
            buf_valid_d = 1'b0;
            buf_tag_d   = IMEM_ADDR;
          end
        end
      end
      // Being in ACC_x at an edge already implies one full cycle elapsed.
      S_ACC_I: begin
        if (!MEM_BUSYWAIT) begin
          state_d     = S_RESP_I;
          rd_d        = 1'b0;
          imem_data_d = MEM_READDATA;
          if (FETCH_BUF_EN != 0) begin
            buf_valid_d = 1'b1;
            buf_data_d  = MEM_READDATA;
          end
        end
      end
      S_ACC_D: begin
        if (!MEM_BUSYWAIT) begin
          state_d     = S_RESP_D;
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          dmem_data_d = wr_q ? '0 : ld_ext;
        end
      end
      S_RESP_I: state_d = S_IDLE;
      S_RESP_D: begin
        state_d    = S_IDLE;
        misalign_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      ld_f3_q     <= '0;
      off_q       <= '0;
      imem_data_q <= '0;
      dmem_data_q <= '0;
      misalign_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      ld_f3_q     <= ld_f3_d;
      off_q       <= off_d;
      imem_data_q <= imem_data_d;
      dmem_data_q <= dmem_data_d;
      misalign_q  <= misalign_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      starve_q    <= starve_d;
    end
  end

  assign MEM_READ       = rd_q;
  assign MEM_WRITE      = wr_q;
  assign MEM_ADDR       = addr_q;
  assign MEM_WRITEDATA  = wdata_q;
  assign MEM_BYTE_EN    = be_q;
  assign IMEM_DATA      = imem_data_q;
  assign DMEM_DATA_READ = dmem_data_q;
  assign DMEM_MISALIGN  = misalign_q;
  assign IMEM_BUSYWAIT  = ireq & (state_q != S_RESP_I);
  assign DMEM_BUSYWAIT  = dreq & (state_q != S_RESP_D);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified main-memory port between the IF-stage fetch and the MA-stage data access of the pipelined RV32IM cpu.
- Replaces the separate imem/dmem pair with a single backing memory that signals busywait.
- Arbitrates between the two requesters, runs the multi-cycle memory handshake, and performs byte-lane alignment and load sign extension.
- Returns per-requester BUSYWAIT to stall the pipeline. A one-entry fetch buffer avoids refetching a stalled PC.

Parameters:
- IF_STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before the fetch is forced.
- FETCH_BUF_EN, 1: 1 enables the one-entry last-fetch buffer.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- IMEM_READ  in  1  fetch request
- IMEM_ADDR  in  32  fetch byte address (PC)
- IMEM_DATA  out  32  fetched instruction
- IMEM_BUSYWAIT  out  1  stall IF
- DMEM_READ  in  4  [3]=load enable, [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- DMEM_WRITE  in  3  [2]=store enable, [1:0]: 00 SB, 01 SH, 10 SW
- DMEM_ADDR  in  32  data byte address
- DMEM_DATA_WRITE  in  32  store data, right-aligned
- DMEM_DATA_READ  out  32  load result, extended
- DMEM_BUSYWAIT  out  1  stall MA
- DMEM_MISALIGN  out  1  one-cycle pulse: data access rejected
- MEM_READ  out  1  memory read strobe
- MEM_WRITE  out  1  memory write strobe
- MEM_ADDR  out  32  word-aligned address {addr[31:2],2'b00}
- MEM_WRITEDATA  out  32  lane-replicated store data
- MEM_BYTE_EN  out  4  byte enables
- MEM_READDATA  in  32  memory read word
- MEM_BUSYWAIT  in  1  memory busy

Behaviour:
- Reset:
  - State IDLE.
  - MEM_READ, MEM_WRITE and DMEM_MISALIGN are 0; MEM_ADDR, MEM_WRITEDATA, MEM_BYTE_EN, IMEM_DATA and DMEM_DATA_READ are 0.
  - Fetch buffer invalid; starve counter 0.
- Reset mid-access: strobes drop at that same edge. The memory model must tolerate abort.
- States: IDLE, ACC_I, ACC_D, RESP_I, RESP_D.
- Request definitions:
  - dreq = DMEM_READ[3] | DMEM_WRITE[2].
  - ireq = IMEM_READ.
  - If both load and store are asserted, the store wins.
  - funct3 011/110/111 on a load is treated as LW.
- IDLE transitions:
  - Grant to data (dreq && !(ireq && starve==IF_STARVE_LIMIT)):
    - If misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0), go to RESP_D with MISALIGN set, issue no memory access, and return data 0.
    - Otherwise latch the request and go to ACC_D.
  - Otherwise, on ireq:
    - Buffer hit (valid and tag==IMEM_ADDR): go to RESP_I using the buffered word.
    - Miss: latch and go to ACC_I.
- Starve counter:
  - Increments on each data grant made while ireq is high.
  - Clears on any fetch grant, or when ireq is low.
- ACC_x:
  - Strobes and address are held stable from registers.
  - Completion is the first edge at which at least one full cycle has elapsed in ACC_x and MEM_BUSYWAIT==0.
  - At completion, capture MEM_READDATA and go to RESP_x.
  - No timeout.
- RESP_x:
  - The requester's BUSYWAIT is low for exactly this cycle; its data output holds the registered result.
  - DMEM_MISALIGN is high in RESP_D if the access was rejected.
  - Next state is always IDLE.
- Busywait: IMEM_BUSYWAIT = ireq & (state!=RESP_I); DMEM_BUSYWAIT = dreq & (state!=RESP_D). Both are combinational from state.
- Minimum latency:
  - Miss: request seen in IDLE at edge 0, ACC at edge 1, completion at edge 2 or later, RESP one cycle.
  - Buffer hit: 1 cycle of busywait.
- Stores:
  - SB: data byte replicated to 4 lanes; byte_en = 0001 << addr[1:0].
  - SH: halfword replicated; byte_en = addr[1] ? 1100 : 0011.
  - SW: byte_en = 1111.
  - Fetch and load: byte_en = 1111, MEM_WRITE = 0.
- Loads: select the byte by addr[1:0] or the halfword by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- Fetch buffer:
  - Updated at ACC_I completion (tag = fetch address).
  - Invalidated by any store whose word address matches the tag, and by reset.
  - Disabled entirely when FETCH_BUF_EN=0.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encoding;
  - load funct3 constants (LB, LH, LW, LBU, LHU);
  - store type constants (SB, SH, SW);
  - the enable bit indices of DMEM_READ and DMEM_WRITE.
- Sub-module lane_align (combinational) produces byte_en and replicated write data from type and addr[1:0], and the extended load data from word, type and addr[1:0]. It is instantiated once for store and once for load paths.

Test Plan:
- Fetch only: memory busy for 3 cycles, IMEM_ADDR=0x00000010, word 0x00500093 -> IMEM_BUSYWAIT high 4 cycles; IMEM_DATA=0x00500093 in RESP_I; MEM_ADDR=0x10, MEM_BYTE_EN=1111.
- Simultaneous requests: LW @0x100 with IF @0x20 -> data granted first, fetch issued only after RESP_D. With data re-requested continuously, the fetch is forced on the 5th arbitration (IF_STARVE_LIMIT=4).
- SB of 0xAB @0x203 -> MEM_BYTE_EN=1000, MEM_WRITEDATA=0xABABABAB. Then LB @0x203 -> 0xFFFFFFAB; LBU @0x203 -> 0x000000AB.
- SH @0x102 -> DMEM_MISALIGN=0. LH @0x101 -> DMEM_MISALIGN pulse, no MEM_READ asserted, DMEM_DATA_READ=0, BUSYWAIT low after 1 cycle.
- Stalled fetch: IF held at 0x40 after completion -> second service is a buffer hit, no MEM_READ. An SW to 0x40 then forces a refetch with the new word.
- RST asserted during ACC_D -> next edge state IDLE, MEM_READ/MEM_WRITE=0, buffer invalid; the next request is serviced normally.
